// File: rtl/ir_ac_cmd_scheduler.sv
// ir_ac_cmd_scheduler
// Holds the air-conditioner user state (power, temperature, mode, fan), applies
// at most one keypad/sleep-timer request per cycle, snapshots the state into
// the two IR frame words and drives the transmitter handshake. Updates that
// arrive while a frame is being prepared, sent or spaced out are merged into
// one follow-up frame. A stalled transmitter is aborted after a timeout and
// the frame is retried.
module ir_ac_cmd_scheduler #(
    parameter int unsigned GAP_CYC     = 200000,
    parameter int unsigned TIMEOUT_CYC = 20000000,
    parameter logic [34:0] F35_CONST   = 35'h0_0840_0200,
    parameter logic [31:0] F32_CONST   = 32'h0804_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_pwr,
    input  logic        key_tup,
    input  logic        key_tdn,
    input  logic        key_mode,
    input  logic        key_fan,
    input  logic        tmr_off,
    input  logic        tx_busy,
    input  logic        tx_done,
    output logic        tx_start,
    output logic [34:0] tx_d35,
    output logic [31:0] tx_d32,
    output logic        power,
    output logic [4:0]  temp,
    output logic [2:0]  mode,
    output logic [1:0]  fan,
    output logic        pending,
    output logic        tx_err
);

    localparam int unsigned GAP_W = (GAP_CYC > 32'd0) ? $clog2(GAP_CYC + 32'd1) : 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 32'd1);
    localparam logic [GAP_W-1:0] GAP_LD  = GAP_W'(GAP_CYC);
    localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);
    localparam logic [TO_W-1:0]  TO_LIM  = TO_W'(TIMEOUT_CYC);
    localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);

    localparam logic [4:0] TEMP_MIN = 5'd16;
    localparam logic [4:0] TEMP_MAX = 5'd30;
    localparam logic [4:0] TEMP_RST = 5'd26;
    localparam logic [2:0] MODE_MAX = 3'd4;

    // ST_LOAD is the cycle right after the snapshot edge: the frame words are
    // captured on the IDLE->LOAD edge so they are stable one cycle ahead of
    // tx_start, which rises on the LOAD->SEND edge.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    state_t            state_r;
    logic [GAP_W-1:0]  gap_r;
    logic [TO_W-1:0]   to_cnt_r;
    logic              power_r;
    logic [4:0]        temp_r;
    logic [2:0]        mode_r;
    logic [1:0]        fan_r;
    logic              pending_r;
    logic              tx_start_r;
    logic              tx_err_r;
    logic [34:0]       tx_d35_r;
    logic [31:0]       tx_d32_r;

    logic              nxt_power_s;
    logic [4:0]        nxt_temp_s;
    logic [2:0]        nxt_mode_s;
    logic [1:0]        nxt_fan_s;
    logic              applied_s;

    // Temperature offset above the 16 degC floor, as carried in the frame.
    function automatic logic [3:0] temp_ofs(input logic [4:0] t);
        temp_ofs = 4'(t - TEMP_MIN);
    endfunction

    // 35-bit frame word: constant upper bits with the state fields in [9:0].
    function automatic logic [34:0] enc_d35(input logic p, input logic [4:0] t,
                                            input logic [2:0] m, input logic [1:0] f);
        enc_d35 = {F35_CONST[34:10], temp_ofs(t), f, p, m};
    endfunction

    // 32-bit frame word: constant upper bits with a mod-16 field checksum.
    function automatic logic [31:0] enc_d32(input logic p, input logic [4:0] t,
                                            input logic [2:0] m, input logic [1:0] f);
        logic [3:0] sum;
        sum     = {1'b0, m} + {3'b000, p} + {2'b00, f} + temp_ofs(t);
        enc_d32 = {F32_CONST[31:4], sum};
    endfunction

    // Pick the highest-priority effective request and compute the next user state.
    // A timer power-off while already off is not a request, so key_pwr may still win.
    always_comb begin
        nxt_power_s = power_r;
        nxt_temp_s  = temp_r;
        nxt_mode_s  = mode_r;
        nxt_fan_s   = fan_r;
        applied_s   = 1'b0;
        if (tmr_off && power_r) begin
            nxt_power_s = 1'b0;
            applied_s   = 1'b1;
        end else if (key_pwr) begin
            nxt_power_s = ~power_r;
            applied_s   = 1'b1;
        end else if (!power_r) begin
            applied_s   = 1'b0;
        end else if (key_mode) begin
            nxt_mode_s  = (mode_r == MODE_MAX) ? 3'd0 : (mode_r + 3'd1);
            applied_s   = 1'b1;
        end else if (key_fan) begin
            nxt_fan_s   = fan_r + 2'd1;
            applied_s   = 1'b1;
        end else if (key_tup) begin
            if (temp_r < TEMP_MAX) begin
                nxt_temp_s = temp_r + 5'd1;
                applied_s  = 1'b1;
            end else begin
                applied_s  = 1'b0;
            end
        end else if (key_tdn) begin
            if (temp_r > TEMP_MIN) begin
                nxt_temp_s = temp_r - 5'd1;
                applied_s  = 1'b1;
            end else begin
                applied_s  = 1'b0;
            end
        end else begin
            applied_s   = 1'b0;
        end
    end

    // User state registers, frame sequencer, inter-frame gap and timeout counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            gap_r      <= '0;
            to_cnt_r   <= '0;
            power_r    <= 1'b0;
            temp_r     <= TEMP_RST;
            mode_r     <= 3'd0;
            fan_r      <= 2'd0;
            pending_r  <= 1'b0;
            tx_start_r <= 1'b0;
            tx_err_r   <= 1'b0;
            tx_d35_r   <= 35'd0;
            tx_d32_r   <= 32'd0;
        end else begin
            power_r    <= nxt_power_s;
            temp_r     <= nxt_temp_s;
            mode_r     <= nxt_mode_s;
            fan_r      <= nxt_fan_s;
            tx_start_r <= 1'b0;
            tx_err_r   <= 1'b0;
            if (gap_r != '0) begin
                gap_r <= gap_r - GAP_ONE;
            end else begin
                gap_r <= gap_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (pending_r && (gap_r == '0) && !tx_busy) begin
                        // Snapshot the pre-edge state; a request on this edge re-arms pending.
                        tx_d35_r  <= enc_d35(power_r, temp_r, mode_r, fan_r);
                        tx_d32_r  <= enc_d32(power_r, temp_r, mode_r, fan_r);
                        pending_r <= applied_s;
                        state_r   <= ST_LOAD;
                    end else begin
                        pending_r <= pending_r | applied_s;
                    end
                end
                ST_LOAD: begin
                    tx_start_r <= 1'b1;
                    to_cnt_r   <= '0;
                    pending_r  <= pending_r | applied_s;
                    state_r    <= ST_SEND;
                end
                ST_SEND: begin
                    to_cnt_r   <= TO_ONE;
                    pending_r  <= pending_r | applied_s;
                    state_r    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tx_done) begin
                        gap_r     <= GAP_LD;
                        pending_r <= pending_r | applied_s;
                        state_r   <= ST_IDLE;
                    end else if (to_cnt_r == TO_LIM) begin
                        // Transmitter stalled: abort and force a retry after the gap.
                        tx_err_r  <= 1'b1;
                        pending_r <= 1'b1;
                        gap_r     <= GAP_LD;
                        state_r   <= ST_IDLE;
                    end else begin
                        to_cnt_r  <= to_cnt_r + TO_ONE;
                        pending_r <= pending_r | applied_s;
                    end
                end
                default: begin
                    pending_r <= pending_r | applied_s;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_start = tx_start_r;
    assign tx_err   = tx_err_r;
    assign tx_d35   = tx_d35_r;
    assign tx_d32   = tx_d32_r;
    assign power    = power_r;
    assign temp     = temp_r;
    assign mode     = mode_r;
    assign fan      = fan_r;
    assign pending  = pending_r;

endmodule

// File: tb/tb_ir_ac_cmd_scheduler.sv
// Scoreboard bench for ir_ac_cmd_scheduler. A reference model tracks the user
// state and predicts every frame (its start edge and both words) and every
// timeout pulse as edge numbers; a negedge monitor pops and compares them.
module tb_ir_ac_cmd_scheduler;

    localparam int G = 12;
    localparam int T = 40;
    localparam logic [34:0] F35 = 35'h0_0840_0200;
    localparam logic [31:0] F32 = 32'h0804_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_pwr = 1'b0, key_tup = 1'b0, key_tdn = 1'b0;
    logic        key_mode = 1'b0, key_fan = 1'b0, tmr_off = 1'b0;
    logic        tx_busy = 1'b0, tx_done = 1'b0;
    logic        tx_start, power, pending, tx_err;
    logic [34:0] tx_d35;
    logic [31:0] tx_d32;
    logic [4:0]  temp;
    logic [2:0]  mode;
    logic [1:0]  fan;

    ir_ac_cmd_scheduler #(.GAP_CYC(G), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst(rst),
        .key_pwr(key_pwr), .key_tup(key_tup), .key_tdn(key_tdn),
        .key_mode(key_mode), .key_fan(key_fan), .tmr_off(tmr_off),
        .tx_busy(tx_busy), .tx_done(tx_done),
        .tx_start(tx_start), .tx_d35(tx_d35), .tx_d32(tx_d32),
        .power(power), .temp(temp), .mode(mode), .fan(fan),
        .pending(pending), .tx_err(tx_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          at;
        logic [34:0] d35;
        logic [31:0] d32;
    } frame_t;

    int     n_chk = 0;
    int     n_fail = 0;
    int     edge_cnt = 0;
    frame_t fq[$];
    int     eq[$];

    // reference model
    bit m_pwr;
    int m_temp, m_mode, m_fan;
    bit m_pend, m_fly;
    int m_start, m_ready;

    // transmitter model
    int stall_mode = 0;   // 0 never stall, 1 always stall, 2 random
    int lat_fix = 0;      // 0 random latency
    int done_edge = -1;
    int busy_off_edge = 0;
    int last_done_edge = 0;

    // monitor records
    int          frames_seen = 0, errs_seen = 0;
    int          last_start_edge = 0, last_err_edge = 0;
    logic [34:0] last_d35 = '0, prev_d35 = '0;
    logic [31:0] last_d32 = '0, prev_d32 = '0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic model_reset();
        m_pwr = 1'b0; m_temp = 26; m_mode = 0; m_fan = 0;
        m_pend = 1'b0; m_fly = 1'b0; m_start = 0; m_ready = 0;
        fq.delete(); eq.delete();
    endtask

    function automatic logic [34:0] exp_d35();
        longint v;
        v = m_mode + 8 * m_pwr + 16 * m_fan + 64 * (m_temp - 16);
        return (F35 & ~35'h3FF) | 35'(v);
    endfunction

    function automatic logic [31:0] exp_d32();
        int s;
        s = (m_mode + m_pwr + m_fan + (m_temp - 16)) % 16;
        return (F32 & ~32'hF) | 32'(s);
    endfunction

    // k = {tmr_off, key_pwr, key_mode, key_fan, key_tup, key_tdn}
    task automatic apply_request(input logic [5:0] k, output bit applied);
        applied = 1'b0;
        if (k[5] && m_pwr) begin m_pwr = 1'b0; applied = 1'b1; end
        else if (k[4]) begin m_pwr = !m_pwr; applied = 1'b1; end
        else if (!m_pwr) applied = 1'b0;
        else if (k[3]) begin m_mode = (m_mode + 1) % 5; applied = 1'b1; end
        else if (k[2]) begin m_fan = (m_fan + 1) % 4; applied = 1'b1; end
        else if (k[1]) begin if (m_temp < 30) begin m_temp++; applied = 1'b1; end end
        else if (k[0]) begin if (m_temp > 16) begin m_temp--; applied = 1'b1; end end
    endtask

    // One clock edge of the reference model, from the pre-edge inputs.
    task automatic model_edge(input logic [5:0] k, input logic done, input logic busy);
        frame_t f;
        bit     applied;
        bit     err;
        err = 1'b0;
        if (!m_fly && m_pend && edge_cnt >= m_ready && !busy) begin
            f.at = edge_cnt + 1; f.d35 = exp_d35(); f.d32 = exp_d32();
            fq.push_back(f);
            m_fly = 1'b1; m_start = edge_cnt + 1; m_pend = 1'b0;
        end else if (m_fly && edge_cnt >= m_start + 2) begin
            if (done) begin
                m_fly = 1'b0; m_ready = edge_cnt + G + 1;
            end else if (edge_cnt == m_start + T + 1) begin
                m_fly = 1'b0; m_ready = edge_cnt + G + 1; err = 1'b1;
                eq.push_back(edge_cnt);
            end
        end
        apply_request(k, applied);
        if (applied || err) m_pend = 1'b1;
    endtask

    task automatic step(input logic [5:0] k);
        {tmr_off, key_pwr, key_mode, key_fan, key_tup, key_tdn} = k;
        @(posedge clk);
        edge_cnt++;
        if (rst) model_edge(k, tx_done, tx_busy);
        #1;
        {tmr_off, key_pwr, key_mode, key_fan, key_tup, key_tdn} = 6'b0;
        if (rst) begin
            if (tx_start) begin
                tx_busy = 1'b1;
                if (stall_mode == 1 || (stall_mode == 2 && $urandom_range(0, 9) == 0)) begin
                    done_edge = -1; busy_off_edge = edge_cnt + 3;
                end else begin
                    done_edge = edge_cnt + ((lat_fix != 0) ? lat_fix : int'($urandom_range(2, 9)));
                    busy_off_edge = done_edge;
                end
            end
            tx_done = (done_edge == edge_cnt + 1);
            if (tx_done) last_done_edge = done_edge;
            if (edge_cnt >= busy_off_edge) tx_busy = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(6'b0);
    endtask

    task automatic wait_frames(input int target, input string name);
        int budget;
        budget = 3 * (G + T) + 50;
        while (frames_seen < target && budget > 0) begin step(6'b0); budget--; end
        chk({name, "_frame_wait"}, frames_seen, target);
    endtask

    task automatic settle();
        int budget;
        budget = 4 * (G + T) + 50;
        while ((m_fly || m_pend || fq.size() > 0) && budget > 0) begin step(6'b0); budget--; end
        idle(G + 3);
    endtask

    // Scoreboard monitor: compares DUT outputs with the model away from the clock edge.
    always @(negedge clk) begin : mon
        frame_t f;
        int     e;
        if (rst) begin
            chk("power", power, m_pwr);
            chk("temp", temp, m_temp);
            chk("mode", mode, m_mode);
            chk("fan", fan, m_fan);
            chk("pending", pending, m_pend);
            if (fq.size() > 0 && fq[0].at == edge_cnt + 1) begin
                chk("d35_before_start", tx_d35, fq[0].d35);
                chk("d32_before_start", tx_d32, fq[0].d32);
            end
            if (tx_start) begin
                if (fq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_tx_start: got start at edge %0d, expected none", edge_cnt);
                end else begin
                    f = fq.pop_front();
                    chk("start_edge", edge_cnt, f.at);
                    chk("d35", tx_d35, f.d35);
                    chk("d32", tx_d32, f.d32);
                end
                frames_seen++;
                last_start_edge = edge_cnt;
                prev_d35 = last_d35; prev_d32 = last_d32;
                last_d35 = tx_d35;   last_d32 = tx_d32;
            end else if (fq.size() > 0 && fq[0].at <= edge_cnt) begin
                f = fq.pop_front();
                n_chk++; n_fail++;
                $display("FAIL missing_tx_start: got none at edge %0d, expected start", f.at);
            end
            if (tx_err) begin
                if (eq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_tx_err: got pulse at edge %0d, expected none", edge_cnt);
                end else begin
                    e = eq.pop_front();
                    chk("err_edge", edge_cnt, e);
                end
                errs_seen++;
                last_err_edge = edge_cnt;
            end else if (eq.size() > 0 && eq[0] <= edge_cnt) begin
                e = eq.pop_front();
                n_chk++; n_fail++;
                $display("FAIL missing_tx_err: got none at edge %0d, expected pulse", e);
            end
        end
    end

    initial begin : stim
        int n0, e0, k;
        logic [5:0] km;
        model_reset();
        idle(3);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_d35", tx_d35, 0);
        chk("rst_d32", tx_d32, 0);
        chk("rst_power", power, 0);
        chk("rst_temp", temp, 26);
        chk("rst_mode", mode, 0);
        chk("rst_fan", fan, 0);
        chk("rst_pending", pending, 0);
        chk("rst_tx_err", tx_err, 0);
        #2 rst = 1'b1;

        // 1: first frame after power-on, latency and encoding
        idle(2);
        lat_fix = 8;
        step(6'b010000);
        e0 = edge_cnt;
        wait_frames(1, "t1");
        chk("t1_latency", last_start_edge - e0, 2);
        chk("t1_d35_lo", last_d35[9:0], 10'b1010_00_1_000);
        chk("t1_d32_lo", last_d32[3:0], 4'd11);
        chk("t1_pending", pending, 0);

        // 2: five temp+ pulses during WAIT merge into one frame
        for (int i = 0; i < 5; i++) step(6'b000010);
        chk("t2_temp", temp, 30);
        wait_frames(2, "t2");
        chk("t2_d35_temp", last_d35[9:6], 4'd14);
        chk("t2_gap", last_start_edge - last_done_edge, G + 2);
        idle(3 * G + 20);
        chk("t2_one_frame", frames_seen, 2);

        // 3: timer-off against power key
        settle();
        n0 = frames_seen;
        step(6'b110000);
        chk("t3_off", power, 0);
        wait_frames(n0 + 1, "t3a");
        settle();
        step(6'b110000);
        chk("t3_on", power, 1);
        wait_frames(n0 + 2, "t3b");
        settle();

        // 4: requests while off are ignored
        step(6'b010000);
        wait_frames(n0 + 3, "t4off");
        settle();
        n0 = frames_seen;
        step(6'b001000); step(6'b000100); step(6'b000010);
        chk("t4_pending", pending, 0);
        chk("t4_temp", temp, 30);
        idle(3 * G + 20);
        chk("t4_no_frame", frames_seen, n0);

        // 5: stalled transmitter, timeout and retry with the same data
        step(6'b010000);
        stall_mode = 1;
        wait_frames(n0 + 1, "t5");
        e0 = last_start_edge;
        stall_mode = 0;
        k = errs_seen;
        for (int i = 0; i < T + 10 && errs_seen == k; i++) step(6'b0);
        chk("t5_err_seen", errs_seen, k + 1);
        chk("t5_err_time", last_err_edge - e0, T + 1);
        wait_frames(n0 + 2, "t5r");
        chk("t5_retry_gap", last_start_edge - last_err_edge, G + 2);
        chk("t5_retry_d35", last_d35, prev_d35);
        chk("t5_retry_d32", last_d32, prev_d32);
        settle();

        // 6: asynchronous reset in WAIT
        n0 = frames_seen;
        step(6'b000100);
        wait_frames(n0 + 1, "t6");
        step(6'b0);
        #2 rst = 1'b0;
        #1;
        chk("t6_tx_start", tx_start, 0);
        chk("t6_d35", tx_d35, 0);
        chk("t6_d32", tx_d32, 0);
        chk("t6_power", power, 0);
        chk("t6_temp", temp, 26);
        chk("t6_fan", fan, 0);
        chk("t6_pending", pending, 0);
        model_reset();
        tx_busy = 1'b0; tx_done = 1'b0; done_edge = -1; busy_off_edge = 0;
        idle(2);
        #2 rst = 1'b1;
        n0 = frames_seen;
        idle(40);
        chk("t6_no_frame", frames_seen, n0);

        // random phase
        lat_fix = 0;
        stall_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            k = $urandom_range(0, 7);
            if (k == 0) km = 6'($urandom_range(0, 63));
            else if (k == 1) km = 6'(1 << $urandom_range(0, 5));
            else km = 6'b0;
            step(km);
        end
        stall_mode = 0;
        settle();
        chk("drain_frames", fq.size(), 0);
        chk("drain_errs", eq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
